// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the program counter, issues one fetch at a time,
// hands the fetched word to decode, and squashes in-flight fetches on redirects.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        drop_q, drop_d;
    logic [31:0] redirect_pc;

    // Redirect targets are forced onto a word boundary.
    assign redirect_pc = redirect_target & ~32'h3;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch below can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        drop_d       = drop_q;

        unique case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    // The old-address request was accepted this cycle, so its response is stale.
                    if (imem_req_ready) begin
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        inst_data_d  = imem_rsp_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + PC_STEP;
                        state_d      = ST_OUT;
                    end
                end
            end

            ST_OUT: begin
                // A redirect squashes the held instruction whether or not decode takes it.
                if (redirect_valid || inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = ST_REQ;
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_data_q  <= 32'd0;
            inst_pc_q    <= 32'd0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            drop_q       <= drop_d;
        end
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
    assign pc             = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random traffic, with delivered
// instructions scored against an architectural next-PC model and an address-keyed memory.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] pc;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .pc              (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_handshakes = 0;
    logic [31:0] model_pc;

    // Memory model state: one outstanding fetch, answered after lat_cfg cycles.
    bit          pending = 1'b0;
    logic [31:0] pend_addr;
    int          cnt = 0;
    int          lat_cfg = 1;
    bit          noise_en = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0001;
        if (a == 32'h0040_0004) return 32'h2009_0002;
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs (memory, decode, redirect), updates the reference model,
    // then advances to 1 time unit after the next rising edge.
    task automatic drive(input bit rdy, input bit irdy, input bit redir, input logic [31:0] tgt);
        if (pending && cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            pending        = 1'b0;
        end else begin
            if (pending) cnt--;
            if (noise_en && !pending && $urandom_range(0, 19) == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hBAD0_0000 | ($urandom & 32'hFFFF);
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
        imem_req_ready = rdy;
        if (reset && imem_req_valid && rdy) begin
            pending   = 1'b1;
            pend_addr = imem_req_addr;
            cnt       = lat_cfg - 1;
        end
        inst_ready      = irdy;
        redirect_valid  = redir;
        redirect_target = tgt;
        if (reset) begin
            if (inst_valid && irdy) begin
                exp_q.push_back('{model_pc, mem_word(model_pc)});
                model_pc += 32'd4;
                n_handshakes++;
            end
            if (redir) model_pc = tgt & ~32'h3;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: scores every handshake and checks hold rules on the side, sampled on the falling edge.
    bit          prev_ok = 1'b0;
    logic        prev_iv, prev_ir, prev_redir, prev_rv, prev_rr;
    logic [31:0] prev_ipc, prev_idata, prev_addr;

    always @(negedge clk) begin
        if (!reset) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok && prev_iv && !prev_ir && !prev_redir) begin
                check("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
                check("hold_inst_pc", inst_pc, prev_ipc);
                check("hold_inst_data", inst_data, prev_idata);
            end
            if (prev_ok && prev_rv && !prev_rr && !prev_redir) begin
                check("hold_req_valid", {31'd0, imem_req_valid}, 32'd1);
                check("hold_req_addr", imem_req_addr, prev_addr);
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_inst", inst_pc, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_inst_pc", inst_pc, e.pc);
                    check("sb_inst_data", inst_data, e.data);
                end
            end
            prev_iv    = inst_valid;
            prev_ir    = inst_ready;
            prev_redir = redirect_valid;
            prev_rv    = imem_req_valid;
            prev_rr    = imem_req_ready;
            prev_ipc   = inst_pc;
            prev_idata = inst_data;
            prev_addr  = imem_req_addr;
            prev_ok    = 1'b1;
        end
    end

    initial begin
        int last_hs;
        int last_cycle;

        reset = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'd0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        inst_ready = 1'b0;
        model_pc = RESET_PC;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_pc", pc, RESET_PC);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rst_req_addr", imem_req_addr, RESET_PC);

        // Sequential fetch with 1-cycle memory latency.
        drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        check("seq0_valid", {31'd0, inst_valid}, 32'd1);
        check("seq0_pc", inst_pc, 32'h0040_0000);
        check("seq0_data", inst_data, 32'h2008_0001);
        drive(0, 1, 0, 0);
        check("seq1_req_addr", imem_req_addr, 32'h0040_0004);
        drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        check("seq1_pc", inst_pc, 32'h0040_0004);
        check("seq1_data", inst_data, 32'h2009_0002);
        drive(0, 1, 0, 0);
        check("seq_pc_after", pc, 32'h0040_0008);

        // Memory backpressure.
        for (int i = 0; i < 4; i++) begin
            check("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("bp_req_addr", imem_req_addr, 32'h0040_0008);
            drive(0, 0, 0, 0);
        end
        drive(1, 0, 0, 0);
        check("bp_accepted", {31'd0, imem_req_valid}, 32'd0);

        // Decode stall.
        drive(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_pc", inst_pc, 32'h0040_0008);
            check("stall_data", inst_data, mem_word(32'h0040_0008));
            check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
            drive(0, 0, 0, 0);
        end
        drive(0, 1, 0, 0);
        check("stall_next_req", {31'd0, imem_req_valid}, 32'd1);
        check("stall_next_addr", imem_req_addr, 32'h0040_000C);

        // Redirect while waiting; response lands two cycles later and is dropped.
        lat_cfg = 3;
        drive(1, 1, 0, 0);
        drive(0, 1, 1, 32'h0040_0103);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        check("rw_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rw_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rw_req_addr", imem_req_addr, 32'h0040_0100);
        lat_cfg = 1;
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("rw_inst_pc", inst_pc, 32'h0040_0100);
        drive(0, 1, 0, 0);

        // Redirect together with request acceptance.
        drive(1, 0, 1, 32'h0040_0200);
        check("ra_pc", pc, 32'h0040_0200);
        check("ra_wait", {31'd0, imem_req_valid}, 32'd0);
        drive(0, 0, 0, 0);
        check("ra_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("ra_req_addr", imem_req_addr, 32'h0040_0200);

        // Redirect together with the response.
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 32'h0040_0300);
        check("rr_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rr_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rr_req_addr", imem_req_addr, 32'h0040_0300);

        // Redirect while holding an instruction that decode does not take.
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("ro_inst_pc", inst_pc, 32'h0040_0300);
        drive(0, 0, 1, 32'h0040_0400);
        check("ro_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("ro_req_addr", imem_req_addr, 32'h0040_0400);

        // PC wrap at the top of the address space.
        drive(0, 0, 1, 32'hFFFF_FFFC);
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_pc", pc, 32'h0000_0000);
        drive(0, 1, 0, 0);
        check("wrap_req_addr0", imem_req_addr, 32'h0000_0000);

        // Reset while waiting; the late response must be ignored.
        lat_cfg = 4;
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0);
        reset = 1'b1;
        exp_q.delete();
        model_pc = RESET_PC;
        check("mr_pc", pc, RESET_PC);
        check("mr_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("mr_req_valid", {31'd0, imem_req_valid}, 32'd1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("mr_late_ignored_valid", {31'd0, inst_valid}, 32'd0);
        check("mr_late_ignored_req", {31'd0, imem_req_valid}, 32'd1);
        check("mr_late_ignored_pc", pc, RESET_PC);
        lat_cfg = 1;
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("mr_fetch_pc", inst_pc, RESET_PC);
        check("mr_fetch_data", inst_data, 32'h2008_0001);
        drive(0, 1, 0, 0);

        // Random traffic scored by the monitor.
        noise_en   = 1'b1;
        last_hs    = n_handshakes;
        last_cycle = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            lat_cfg = 1 + $urandom_range(0, 3);
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 3, tgt);
            if (n_handshakes != last_hs) begin
                last_hs    = n_handshakes;
                last_cycle = i;
            end else if (i - last_cycle > 300) begin
                n_checks++;
                n_errors++;
                $display("FAIL watchdog: no instruction delivered for %0d cycles (cycle %0d)", i - last_cycle, i);
                break;
            end
        end
        noise_en = 1'b0;
        check("rand_progress", {31'd0, n_handshakes > 100}, 32'd1);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
